// File: rtl/muldiv_pkg.sv
// Shared opcode and FSM encodings for the iterative multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } muldiv_state_e;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for divide.
module muldiv_step #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  is_div,
  input  logic [DATA_WIDTH-1:0] acc,
  input  logic [DATA_WIDTH-1:0] lo,
  input  logic [DATA_WIDTH-1:0] opnd,
  output logic [DATA_WIDTH-1:0] acc_c,
  output logic [DATA_WIDTH-1:0] lo_c
);

  logic [DATA_WIDTH:0] sum;
  logic [DATA_WIDTH:0] shifted;
  logic                ge;

  always_comb begin
    sum     = {1'b0, acc} + (lo[0] ? {1'b0, opnd} : '0);
    shifted = {acc, lo[DATA_WIDTH-1]};
    ge      = (shifted >= {1'b0, opnd});
    acc_c   = sum[DATA_WIDTH:1];
    lo_c    = {sum[0], lo[DATA_WIDTH-1:1]};
    if (is_div) begin
      // Partial remainder stays below the divisor, so the top bit is always zero.
      acc_c = ge ? DATA_WIDTH'(shifted - {1'b0, opnd}) : DATA_WIDTH'(shifted);
      lo_c  = {lo[DATA_WIDTH-2:0], ge};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M-style multiply/divide unit, one result bit per cycle with valid/ready handshakes.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned OPCODE_LENGTH = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    SrcA,
  input  logic [DATA_WIDTH-1:0]    SrcB,
  input  logic [OPCODE_LENGTH-1:0] Operation,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    Result,
  output logic                     busy
);

  localparam int unsigned         W        = DATA_WIDTH;
  localparam int unsigned         CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0]    CNT_INIT = CNT_W'(DATA_WIDTH - 1);
  localparam logic [W-1:0]        MIN_NEG  = {1'b1, {(W-1){1'b0}}};

  muldiv_state_e    state_q, state_d;
  muldiv_op_e       op_q, op_d, op_in;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic [W-1:0]     opnd_q, opnd_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [W-1:0]     lo_q, lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     result_q, result_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;

  logic             sign_a, sign_b, conv_a, conv_b;
  logic             div_by_zero, overflow;
  logic [W-1:0]     abs_a, abs_b;
  logic [W-1:0]     step_acc_c, step_lo_c;
  logic [2*W-1:0]   product, product_fix;
  logic [W-1:0]     quot_fix, rem_fix;

  muldiv_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
    .is_div (op_q[2]),
    .acc    (acc_q),
    .lo     (lo_q),
    .opnd   (opnd_q),
    .acc_c  (step_acc_c),
    .lo_c   (step_lo_c)
  );

  // Next-state, operand preparation and sign-corrected result selection.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    result_d  = result_q;

    op_in       = muldiv_op_e'(3'(Operation));
    sign_a      = SrcA[W-1];
    sign_b      = SrcB[W-1];
    conv_a      = op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    conv_b      = op_in inside {OP_MULH, OP_DIV, OP_REM};
    abs_a       = (conv_a && sign_a) ? -SrcA : SrcA;
    abs_b       = (conv_b && sign_b) ? -SrcB : SrcB;
    div_by_zero = op_in[2] && (SrcB == '0);
    overflow    = (op_in inside {OP_DIV, OP_REM}) && (SrcA == MIN_NEG) && (&SrcB);

    product     = {step_acc_c, step_lo_c};
    product_fix = neg_res_q ? -product : product;
    quot_fix    = neg_res_q ? -step_lo_c : step_lo_c;
    rem_fix     = neg_rem_q ? -step_acc_c : step_acc_c;

    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid && in_ready_q) begin
            op_d      = op_in;
            neg_res_d = (conv_a & sign_a) ^ (conv_b & sign_b);
            neg_rem_d = conv_a & sign_a;
            acc_d     = '0;
            cnt_d     = CNT_INIT;
            if (div_by_zero) begin
              state_d  = S_DONE;
              result_d = op_in[1] ? SrcA : '1;
            end else if (overflow) begin
              state_d  = S_DONE;
              result_d = op_in[1] ? '0 : SrcA;
            end else begin
              state_d = S_CALC;
              opnd_d  = op_in[2] ? abs_b : abs_a;
              lo_d    = op_in[2] ? abs_a : abs_b;
            end
          end
        end
        S_CALC: begin
          acc_d = step_acc_c;
          lo_d  = step_lo_c;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == '0) begin
            state_d = S_DONE;
            cnt_d   = '0;
            case (op_q)
              OP_MUL:                        result_d = product_fix[W-1:0];
              OP_MULH, OP_MULHSU, OP_MULHU:  result_d = product_fix[2*W-1:W];
              OP_DIV, OP_DIVU:               result_d = quot_fix;
              default:                       result_d = rem_fix;
            endcase
          end
        end
        S_DONE: begin
          if (out_valid_q && out_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Result is sign-corrected on DONE entry and presented the following cycle.
    out_valid_d = (state_q == S_DONE) && (state_d == S_DONE);
    in_ready_d  = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= OP_MUL;
      neg_res_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      opnd_q      <= '0;
      acc_q       <= '0;
      lo_q        <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      neg_res_q   <= neg_res_d;
      neg_rem_q   <= neg_rem_d;
      opnd_q      <= opnd_d;
      acc_q       <= acc_d;
      lo_q        <= lo_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign Result    = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: arithmetic results, latency, backpressure, flush and reset.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic [2:0]  Operation;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Result;
  logic        busy;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.DATA_WIDTH(32), .OPCODE_LENGTH(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .Operation (Operation),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Result    (Result),
    .busy      (busy)
  );

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat;
    lat = -1;
    @(negedge clk);
    for (int i = 0; i < 50 && in_ready !== 1'b1; i++) @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s in_ready: got %b expected 1", name, in_ready);
    end
    Operation = op; SrcA = a; SrcB = b; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) begin lat = i; break; end
    end
    vectors++;
    if (lat != exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
    end
    vectors++;
    if (Result !== exp) begin
      errors++;
      $display("FAIL %s result: got %h expected %h", name, Result, exp);
    end
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s release: got valid=%b ready=%b busy=%b expected 0 1 0",
               name, out_valid, in_ready, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    SrcA = '0; SrcB = '0; Operation = '0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({in_ready, out_valid, busy} !== 3'b000 || Result !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: got ready=%b valid=%b busy=%b result=%h expected all 0",
               in_ready, out_valid, busy, Result);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_multiply();
    run_op("mul_7_x_m3",      3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    run_op("mul_low",         3'b000, 32'h1234_5678, 32'h10,       32'h2345_6780, 33);
    run_op("mulhu_max",       3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    run_op("mulh_m1_m1",      3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33);
    run_op("mulh_min_min",    3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
    run_op("mulhsu_min_2p31", 3'b010, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000, 33);
  endtask

  task automatic test_divide();
    run_op("div_m7_2",  3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
    run_op("rem_m7_2",  3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
    run_op("div_7_m2",  3'b100, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
    run_op("rem_7_m2",  3'b110, 32'd7,         32'hFFFF_FFFE, 32'd1,         33);
    run_op("divu_100_7", 3'b101, 32'd100,      32'd7,         32'd14,        33);
    run_op("remu_100_7", 3'b111, 32'd100,      32'd7,         32'd2,         33);
  endtask

  task automatic test_div_special();
    run_op("divu_by_zero", 3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
    run_op("rem_by_zero",  3'b110, 32'd5,         32'd0,         32'd5,         1);
    run_op("div_overflow", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem_overflow", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
  endtask

  task automatic test_backpressure();
    int lat;
    lat = -1;
    @(negedge clk);
    Operation = 3'b000; SrcA = 32'd3; SrcB = 32'd5; in_valid = 1'b1;
    @(posedge clk);
    #1 Operation = 3'b101; SrcA = 32'd9; SrcB = 32'd3;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) begin lat = i; break; end
    end
    vectors++;
    if (lat != 33) begin
      errors++;
      $display("FAIL stall_latency: got %0d expected 33", lat);
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (Result !== 32'd15 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold cycle %0d: got result=%h valid=%b ready=%b expected 0000000f 1 0",
                 i, Result, out_valid, in_ready);
      end
    end
    @(negedge clk) begin out_ready = 1'b1; in_valid = 1'b0; end
    @(posedge clk); #1 out_ready = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stall_release: got valid=%b ready=%b busy=%b expected 0 1 0",
               out_valid, in_ready, busy);
    end
  endtask

  task automatic test_flush();
    logic rose;
    @(negedge clk);
    Operation = 3'b101; SrcA = 32'd1000; SrcB = 32'd3; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; Operation = 3'b000; SrcA = 32'd2; SrcB = 32'd2;
    @(posedge clk); #1;
    vectors++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_idle: got valid=%b busy=%b ready=%b expected 0 0 1",
               out_valid, busy, in_ready);
    end
    @(negedge clk) begin flush = 1'b0; in_valid = 1'b0; end
    rose = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || busy !== 1'b0) rose = 1'b1;
    end
    vectors++;
    if (rose !== 1'b0) begin
      errors++;
      $display("FAIL flush_discard: got activity=%b expected 0", rose);
    end
    run_op("after_flush_divu", 3'b101, 32'd1000, 32'd3, 32'd333, 33);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    Operation = 3'b000; SrcA = 32'd11; SrcB = 32'd13; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    vectors++;
    if ({in_ready, out_valid, busy} !== 3'b000 || Result !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid: got ready=%b valid=%b busy=%b result=%h expected all 0",
               in_ready, out_valid, busy, Result);
    end
    @(negedge clk) rst_n = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_pre_edge: got in_ready=%b expected 0", in_ready);
    end
    @(posedge clk); #1;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_release: got ready=%b valid=%b expected 1 0", in_ready, out_valid);
    end
    run_op("after_reset_mul", 3'b000, 32'd11, 32'd13, 32'd143, 33);
  endtask

  initial begin
    test_reset();
    test_multiply();
    test_divide();
    test_div_special();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
